// File: rtl/gol_pkg.sv
// Shared types and TGA layout constants for the Game of Life pattern loader.
package gol_pkg;

    localparam int unsigned DEF_GRID_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        ID_SKIP,
        PIXELS,
        TRAILER,
        ERROR,
        FINISH
    } loader_state_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_TYPE  = 3'd1,
        ERR_SIZE  = 3'd2,
        ERR_BPP   = 3'd3,
        ERR_TRUNC = 3'd4
    } loader_err_t;

    // Byte offsets within the 18-byte TGA header
    localparam logic [4:0] OFF_ID_LEN    = 5'd0;
    localparam logic [4:0] OFF_CMAP_TYPE = 5'd1;
    localparam logic [4:0] OFF_IMG_TYPE  = 5'd2;
    localparam logic [4:0] OFF_WIDTH_LO  = 5'd12;
    localparam logic [4:0] OFF_WIDTH_HI  = 5'd13;
    localparam logic [4:0] OFF_HEIGHT_LO = 5'd14;
    localparam logic [4:0] OFF_HEIGHT_HI = 5'd15;
    localparam logic [4:0] OFF_BPP       = 5'd16;
    localparam logic [4:0] OFF_DESC      = 5'd17;

    localparam logic [7:0] IMG_TRUECOLOR = 8'd2;
    localparam logic [7:0] IMG_GRAY      = 8'd3;

endpackage

// File: rtl/gol_tga_header.sv
// Captures TGA header fields from the byte stream and validates them on the final header byte.
module gol_tga_header
    import gol_pkg::*;
#(
    parameter int unsigned GRID_SIZE = DEF_GRID_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  data,
    output logic [7:0]  id_len,
    output logic        bpp24,
    output logic        top_left,
    output logic        hdr_ok,
    output logic        hdr_err,
    output loader_err_t hdr_code
);

    logic [4:0] cnt;
    logic [7:0] cmap, itype, w_lo, w_hi, h_lo, h_hi, bpp;
    logic       desc_top;
    logic       at_last, type_ok, size_ok, bpp_ok;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt      <= '0;
            id_len   <= '0;
            cmap     <= '0;
            itype    <= '0;
            w_lo     <= '0;
            w_hi     <= '0;
            h_lo     <= '0;
            h_hi     <= '0;
            bpp      <= '0;
            desc_top <= 1'b0;
        end else if (byte_en) begin
            if (cnt != OFF_DESC) cnt <= cnt + 5'd1;
            case (cnt)
                OFF_ID_LEN:    id_len   <= data;
                OFF_CMAP_TYPE: cmap     <= data;
                OFF_IMG_TYPE:  itype    <= data;
                OFF_WIDTH_LO:  w_lo     <= data;
                OFF_WIDTH_HI:  w_hi     <= data;
                OFF_HEIGHT_LO: h_lo     <= data;
                OFF_HEIGHT_HI: h_hi     <= data;
                OFF_BPP:       bpp      <= data;
                OFF_DESC:      desc_top <= data[5];
                default: ;
            endcase
        end
    end

    always_comb begin
        at_last = byte_en && (cnt == OFF_DESC);
        type_ok = (cmap == 8'd0) && (itype == IMG_GRAY || itype == IMG_TRUECOLOR);
        size_ok = ({w_hi, w_lo} == 16'(GRID_SIZE)) && ({h_hi, h_lo} == 16'(GRID_SIZE));
        bpp_ok  = (itype == IMG_GRAY) ? (bpp == 8'd8) : (bpp == 8'd24);
        if (!type_ok)      hdr_code = ERR_TYPE;
        else if (!size_ok) hdr_code = ERR_SIZE;
        else if (!bpp_ok)  hdr_code = ERR_BPP;
        else               hdr_code = ERR_NONE;
        hdr_ok  = at_last && (hdr_code == ERR_NONE);
        hdr_err = at_last && (hdr_code != ERR_NONE);
        bpp24   = (bpp == 8'd24);
        // Descriptor is still on the bus when the checks fire, so bypass the register
        top_left = at_last ? data[5] : desc_top;
    end

endmodule

// File: rtl/gol_tga_loader.sv
// Streaming TGA reader: validates the header, then issues one grid cell write per pixel.
module gol_tga_loader
    import gol_pkg::*;
#(
    parameter int unsigned GRID_SIZE = DEF_GRID_SIZE,
    parameter int unsigned ADDR_W    = $clog2(GRID_SIZE * GRID_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              cell_we,
    output logic [ADDR_W-1:0] cell_addr,
    output logic              cell_alive,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code
);

    localparam int unsigned XY_W = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
    localparam logic [XY_W-1:0] XY_MAX = XY_W'(GRID_SIZE - 1);

    loader_state_t state;
    loader_err_t   err_q;
    logic [XY_W-1:0] x, y;
    logic [1:0]  pb;
    logic        any_nz, top_q;
    logic [7:0]  skip_cnt;

    logic        xfer, hdr_en, px_last, final_px, nz;
    logic [7:0]  id_len;
    logic        bpp24, top_left, hdr_ok, hdr_err;
    loader_err_t hdr_code;

    always_comb begin
        xfer     = in_valid && in_ready;
        hdr_en   = xfer && (state == HEADER);
        nz       = (in_data != 8'd0);
        px_last  = !bpp24 || (pb == 2'd2);
        final_px = (x == XY_MAX) && (top_q ? (y == XY_MAX) : (y == '0));
    end

    gol_tga_header #(.GRID_SIZE(GRID_SIZE)) u_header (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start && state == IDLE),
        .byte_en  (hdr_en),
        .data     (in_data),
        .id_len   (id_len),
        .bpp24    (bpp24),
        .top_left (top_left),
        .hdr_ok   (hdr_ok),
        .hdr_err  (hdr_err),
        .hdr_code (hdr_code)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            err_q      <= ERR_NONE;
            in_ready   <= 1'b0;
            cell_we    <= 1'b0;
            cell_addr  <= '0;
            cell_alive <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= '0;
            x          <= '0;
            y          <= '0;
            pb         <= '0;
            any_nz     <= 1'b0;
            top_q      <= 1'b0;
            skip_cnt   <= '0;
        end else begin
            cell_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= HEADER;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    err_code <= ERR_NONE;
                    err_q    <= ERR_NONE;
                end
                HEADER: if (xfer) begin
                    if (in_last) begin
                        state <= FINISH; in_ready <= 1'b0; busy <= 1'b0; done <= 1'b1;
                        err_code <= ERR_TRUNC;
                    end else if (hdr_err) begin
                        state <= ERROR;
                        err_q <= hdr_code;
                    end else if (hdr_ok) begin
                        x        <= '0;
                        y        <= top_left ? '0 : XY_MAX;
                        top_q    <= top_left;
                        pb       <= '0;
                        any_nz   <= 1'b0;
                        skip_cnt <= id_len;
                        state    <= (id_len != 8'd0) ? ID_SKIP : PIXELS;
                    end
                end
                ID_SKIP: if (xfer) begin
                    if (in_last) begin
                        state <= FINISH; in_ready <= 1'b0; busy <= 1'b0; done <= 1'b1;
                        err_code <= ERR_TRUNC;
                    end else begin
                        skip_cnt <= skip_cnt - 8'd1;
                        if (skip_cnt == 8'd1) state <= PIXELS;
                    end
                end
                PIXELS: if (xfer) begin
                    if (px_last) begin
                        cell_we    <= 1'b1;
                        cell_addr  <= ADDR_W'(y) * ADDR_W'(GRID_SIZE) + ADDR_W'(x);
                        cell_alive <= any_nz | nz;
                        any_nz     <= 1'b0;
                        pb         <= '0;
                        x          <= (x == XY_MAX) ? '0 : x + 1'b1;
                        if (x == XY_MAX)
                            y <= top_q ? ((y == XY_MAX) ? '0 : y + 1'b1)
                                       : ((y == '0) ? XY_MAX : y - 1'b1);
                    end else begin
                        pb     <= pb + 2'd1;
                        any_nz <= any_nz | nz;
                    end
                    // A final-pixel in_last ends cleanly; any earlier in_last is truncation
                    if (px_last && final_px && !in_last) begin
                        state <= TRAILER;
                    end else if (in_last) begin
                        state <= FINISH; in_ready <= 1'b0; busy <= 1'b0; done <= 1'b1;
                        err_code <= (px_last && final_px) ? ERR_NONE : ERR_TRUNC;
                    end
                end
                TRAILER, ERROR: if (xfer && in_last) begin
                    state <= FINISH; in_ready <= 1'b0; busy <= 1'b0; done <= 1'b1;
                    err_code <= (state == ERROR) ? err_q : ERR_NONE;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gol_tga_loader.sv
// Directed bench for gol_tga_loader: table of TGA files plus reset and mid-load corner cases.
module tb_gol_tga_loader;

    localparam int unsigned GS = 4;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready, cell_we, cell_alive, busy, done;
    logic [AW-1:0] cell_addr;
    logic [2:0]    err_code;

    gol_tga_loader #(.GRID_SIZE(GS), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .cell_we    (cell_we),
        .cell_addr  (cell_addr),
        .cell_alive (cell_alive),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cmap;
        int itype;
        int width;
        int bpp;
        int desc;
        int id_len;
        int npix;
        int footer;
        int cut;
        int exp_err;
        int exp_wr;
    } case_t;

    case_t         cases[10];
    logic [7:0]    stream[$];
    logic [AW-1:0] wr_addr[$];
    logic          wr_alive[$];
    int            done_cnt = 0;
    logic [2:0]    done_err = '0;
    int            passed = 0;
    int            total = 0;

    always @(negedge clk) begin
        if (cell_we) begin
            wr_addr.push_back(cell_addr);
            wr_alive.push_back(cell_alive);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_err = err_code;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit pix_alive(input int k, input int itype);
        if (itype == 2) return (k % 3) == 0;
        return (k % 2) == 1;
    endfunction

    task automatic build(input case_t c);
        stream.delete();
        stream.push_back(8'(c.id_len));
        stream.push_back(8'(c.cmap));
        stream.push_back(8'(c.itype));
        for (int i = 3; i < 12; i++) stream.push_back(8'h00);
        stream.push_back(8'(c.width));
        stream.push_back(8'(c.width >> 8));
        stream.push_back(8'(GS));
        stream.push_back(8'h00);
        stream.push_back(8'(c.bpp));
        stream.push_back(8'(c.desc));
        for (int i = 0; i < c.id_len; i++) stream.push_back(8'hA5);
        for (int k = 0; k < c.npix; k++) begin
            if (c.bpp == 24) begin
                stream.push_back(8'h00);
                stream.push_back(8'h00);
                stream.push_back(pix_alive(k, c.itype) ? 8'h01 : 8'h00);
            end else begin
                stream.push_back(pix_alive(k, c.itype) ? 8'hFF : 8'h00);
            end
        end
        for (int i = 0; i < c.footer; i++) stream.push_back(8'h5A);
        if (c.cut > 0)
            while (stream.size() > c.cut) void'(stream.pop_back());
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit with_last, output int stalls);
        int   i = 0;
        int   guard = 0;
        logic rdy;
        stalls = 0;
        while (i < n && guard < 1000) begin
            in_data  = stream[i];
            in_valid = 1'b1;
            in_last  = with_last && (i == n - 1);
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) i++;
            else if (i > 0) stalls++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (i < n) check("send_timeout", i, n);
    endtask

    task automatic run_case(input int idx);
        case_t c;
        int    wb, db, stalls, nwr, row, xx, yy;
        c = cases[idx];
        build(c);
        wb = wr_addr.size();
        db = done_cnt;
        do_start();
        check($sformatf("c%0d_busy_after_start", idx), int'(busy), 1);
        send(stream.size(), 1'b1, stalls);
        for (int t = 0; t < 10 && done_cnt == db; t++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
        nwr = wr_addr.size() - wb;
        check($sformatf("c%0d_done_pulses", idx), done_cnt - db, 1);
        check($sformatf("c%0d_done_err", idx), int'(done_err), c.exp_err);
        check($sformatf("c%0d_err_held", idx), int'(err_code), c.exp_err);
        check($sformatf("c%0d_busy_after_done", idx), int'(busy), 0);
        check($sformatf("c%0d_ready_stalls", idx), stalls, 0);
        check($sformatf("c%0d_write_count", idx), nwr, c.exp_wr);
        for (int k = 0; k < nwr && k < c.exp_wr; k++) begin
            row = k / GS;
            xx  = k % GS;
            yy  = ((c.desc & 32) != 0) ? row : (GS - 1 - row);
            check($sformatf("c%0d_addr%0d", idx, k), int'(wr_addr[wb + k]), xx + GS * yy);
            check($sformatf("c%0d_alive%0d", idx, k), int'(wr_alive[wb + k]),
                  int'(pix_alive(k, c.itype)));
        end
    endtask

    initial begin
        int stalls, db;

        //           cmap type w  bpp desc id npix ftr cut err wr
        cases[0] = '{0, 3, 4, 8,  32, 0, 16, 0,  0,  0, 16};
        cases[1] = '{0, 3, 4, 8,  0,  0, 16, 0,  0,  0, 16};
        cases[2] = '{0, 2, 4, 24, 32, 3, 16, 26, 0,  0, 16};
        cases[3] = '{0, 3, 5, 8,  32, 0, 16, 0,  0,  2, 0};
        cases[4] = '{0, 3, 4, 8,  32, 0, 5,  0,  0,  4, 5};
        cases[5] = '{0, 1, 4, 8,  32, 0, 16, 0,  0,  1, 0};
        cases[6] = '{0, 3, 4, 24, 32, 0, 16, 0,  0,  3, 0};
        cases[7] = '{1, 3, 5, 8,  32, 0, 16, 0,  0,  1, 0};
        cases[8] = '{0, 3, 4, 8,  32, 0, 16, 0,  10, 4, 0};
        cases[9] = '{0, 3, 4, 8,  0,  2, 16, 2,  0,  0, 16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cell_we", int'(cell_we), 0);
        check("rst_cell_addr", int'(cell_addr), 0);
        check("rst_cell_alive", int'(cell_alive), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err_code", int'(err_code), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_case(i);

        // Reset in the middle of the pixel stream, then reload a clean file
        build(cases[0]);
        db = done_cnt;
        do_start();
        send(18 + 6, 1'b0, stalls);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_cell_we", int'(cell_we), 0);
        check("midrst_cell_addr", int'(cell_addr), 0);
        check("midrst_cell_alive", int'(cell_alive), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err_code", int'(err_code), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - db, 0);
        check("midrst_idle_not_ready", int'(in_ready), 0);
        run_case(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
